// File: rtl/rng_share_if.sv
// Purpose: bundles the requester, generator and output-stream signals of rng_share_arbiter.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer stalls the stream; out_valid never drops mid-burst.
//
// Signals:
//   req/len   per-requester burst request (level) and packed burst lengths (L means L+1 samples)
//   gnt       one-hot, one-cycle pulse marking the accepted requester
//   rng_in    free-running generator sample
//   out_*     shared valid/ready sample stream tagged with the owning requester id
//   busy      high while a burst is being streamed
interface rng_share_if #(
    parameter int N         = 4,
    parameter int OUT_WIDTH = 16,
    parameter int LEN_W     = 4,
    parameter int ID_W      = $clog2(N)
);
    logic [N-1:0]         req;
    logic [N*LEN_W-1:0]   len;
    logic [N-1:0]         gnt;
    logic [OUT_WIDTH-1:0] rng_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [ID_W-1:0]      out_id;
    logic                 out_last;
    logic                 busy;

    // master: the arbiter, which drives the output stream
    modport master (
        input  req, len, rng_in, out_ready,
        output gnt, out_valid, out_data, out_id, out_last, busy
    );

    // slave: requesters, generator and consumer
    modport slave (
        output req, len, rng_in, out_ready,
        input  gnt, out_valid, out_data, out_id, out_last, busy
    );
endinterface

// File: rtl/rng_share_arbiter.sv
// Purpose: round-robin shares one free-running random generator among N burst requesters.
// Latency: gnt and the first beat appear one cycle after req is sampled in IDLE; one idle bubble between bursts.
// Backpressure: out_ready low holds out_data/out_id/out_last and keeps out_valid high; no sample is skipped or reused.
//
// Ports:
//   clk, rst   clock; asynchronous active-low reset
//   bus        rng_share_if.master (req, len, rng_in, out_ready in; gnt, out_valid, out_data,
//              out_id, out_last, busy out)
module rng_share_arbiter #(
    parameter int N         = 4,
    parameter int OUT_WIDTH = 16,
    parameter int LEN_W     = 4,
    parameter int ID_W      = $clog2(N)
) (
    input  logic       clk,
    input  logic       rst,
    rng_share_if.master bus
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      rr_ptr, rr_nxt;
    logic [LEN_W-1:0]     remaining, rem_nxt;
    logic [N-1:0]         gnt_nxt;
    logic                 valid_nxt, last_nxt, busy_nxt;
    logic [OUT_WIDTH-1:0] data_nxt;
    logic [ID_W-1:0]      id_nxt;

    logic [LEN_W-1:0]     len_arr [N];
    logic                 found;
    logic [ID_W-1:0]      win;
    logic [ID_W-1:0]      cand;
    int                   c;

    for (genvar g = 0; g < N; g++) begin : g_len
        assign len_arr[g] = bus.len[g*LEN_W +: LEN_W];
    end

    // First set request scanning upward from the pointer, wrapping at N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            cand = ID_W'(c);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        rem_nxt   = remaining;
        gnt_nxt   = '0;
        valid_nxt = bus.out_valid;
        data_nxt  = bus.out_data;
        id_nxt    = bus.out_id;
        last_nxt  = bus.out_last;
        busy_nxt  = bus.busy;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt[win] = 1'b1;
                    id_nxt       = win;
                    rem_nxt      = len_arr[win];
                    data_nxt     = bus.rng_in;
                    valid_nxt    = 1'b1;
                    busy_nxt     = 1'b1;
                    last_nxt     = (len_arr[win] == '0);
                    state_nxt    = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_valid && bus.out_ready) begin
                    if (bus.out_last) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                        rr_nxt    = (bus.out_id == ID_W'(N-1)) ? '0 : bus.out_id + 1'b1;
                    end else begin
                        // A fresh sample is taken only when the previous one was consumed.
                        rem_nxt  = remaining - LEN_W'(1);
                        data_nxt = bus.rng_in;
                        last_nxt = (remaining == LEN_W'(1));
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            remaining     <= '0;
            bus.gnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_nxt;
            remaining     <= rem_nxt;
            bus.gnt       <= gnt_nxt;
            bus.out_valid <= valid_nxt;
            bus.out_data  <= data_nxt;
            bus.out_id    <= id_nxt;
            bus.out_last  <= last_nxt;
            bus.busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Purpose: randomized scoreboard bench for rng_share_arbiter with a queue-based round-robin model.
// Latency: expects gnt and the first beat one cycle after req is sampled in IDLE.
// Backpressure: drives directed and random out_ready; checks that held beats stay stable.
module tb_rng_share_arbiter;
    localparam int N         = 4;
    localparam int OUT_WIDTH = 16;
    localparam int LEN_W     = 4;
    localparam int ID_W      = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rng_share_if #(.N(N), .OUT_WIDTH(OUT_WIDTH), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    rng_share_arbiter #(.N(N), .OUT_WIDTH(OUT_WIDTH), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int              gnt_q  [$];
    beat_t           beat_q [$];
    logic            ready_pat [$];
    logic [ID_W-1:0] prio [$];
    bit              ready_rand = 1'b0;
    logic [OUT_WIDTH-1:0] rng_at_edge = '0;
    int              cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Priority order held as a rotating list; the winner moves the head to winner+1.
    function automatic int model_pick(input logic [N-1:0] mask);
        int w = -1;
        logic [ID_W-1:0] h;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && mask[prio[k]]) w = int'(prio[k]);
        end
        if (w >= 0) begin
            do begin
                h = prio.pop_front();
                prio.push_back(h);
            end while (int'(h) != w);
        end
        return w;
    endfunction

    task automatic model_reset();
        prio.delete();
        for (int k = 0; k < N; k++) prio.push_back(ID_W'(k));
    endtask

    task automatic expect_burst(input int w, input logic [N*LEN_W-1:0] lens);
        logic [LEN_W-1:0] l;
        l = lens[w*LEN_W +: LEN_W];
        gnt_q.push_back(w);
        for (int k = 0; k <= int'(l); k++) begin
            beat_q.push_back('{id: ID_W'(w), last: (k == int'(l))});
        end
    endtask

    task automatic wait_gnt();
        int t;
        for (t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) break;
        end
        if (t == 20) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            if (beat_q.size() == 0 && !bus.out_valid) break;
        end
        if (t == 400) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Request, take the grant, then drop req and scramble len to show both are committed.
    task automatic run_burst(input logic [N-1:0] mask, input logic [N*LEN_W-1:0] lens);
        bus.req = mask;
        bus.len = lens;
        expect_burst(model_pick(mask), lens);
        wait_gnt();
        bus.req = '0;
        bus.len = (N*LEN_W)'($urandom);
        wait_idle();
    endtask

    // Generator and consumer: change well after the edge so the DUT sees stable values.
    initial begin
        forever begin
            @(posedge clk); #2;
            rng_at_edge = bus.rng_in;
            bus.rng_in  = OUT_WIDTH'($urandom);
            cyc++;
            if (ready_pat.size() > 0) bus.out_ready = ready_pat.pop_front();
            else if (ready_rand)      bus.out_ready = 1'($urandom_range(0, 1));
            else                      bus.out_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever a new beat or a grant appears.
    logic                 pv = 1'b0, phs = 1'b0;
    logic [OUT_WIDTH-1:0] hd;
    logic [ID_W-1:0]      hid;
    logic                 hl;
    always @(negedge clk) begin
        beat_t b;
        int    e;
        if (!rst) begin
            pv  = 1'b0;
            phs = 1'b0;
        end else begin
            if (bus.gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 32'(bus.gnt), 32'd0);
                end else begin
                    e = gnt_q.pop_front();
                    check("gnt_onehot", 32'(bus.gnt), 32'd1 << e);
                    check("valid_with_gnt", 32'(bus.out_valid), 32'd1);
                end
            end
            check("busy_eq_valid", 32'(bus.busy), 32'(bus.out_valid));
            if (pv && !phs) check("valid_held", 32'(bus.out_valid), 32'd1);
            if (bus.out_valid) begin
                if (!pv || phs) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_id",   32'(bus.out_id),   32'(b.id));
                        check("beat_last", 32'(bus.out_last), 32'(b.last));
                        check("beat_data", 32'(bus.out_data), 32'(rng_at_edge));
                    end
                end else begin
                    check("hold_data", 32'(bus.out_data), 32'(hd));
                    check("hold_id",   32'(bus.out_id),   32'(hid));
                    check("hold_last", 32'(bus.out_last), 32'(hl));
                end
                hd  = bus.out_data;
                hid = bus.out_id;
                hl  = bus.out_last;
            end
            pv  = bus.out_valid;
            phs = bus.out_valid & bus.out_ready;
        end
    end

    initial begin
        int last_g;
        int w;
        bus.req       = '0;
        bus.len       = '0;
        bus.rng_in    = '0;
        bus.out_ready = 1'b1;
        model_reset();

        #1 rst = 1'b0;
        #3;
        check("rst_gnt",   32'(bus.gnt),       32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_id",    32'(bus.out_id),    32'd0);
        check("rst_last",  32'(bus.out_last),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Fairness: all requesting, single-beat bursts, grants two cycles apart.
        bus.req = 4'hF;
        bus.len = '0;
        for (int g = 0; g < 6; g++) expect_burst(model_pick(4'hF), '0);
        last_g = 0;
        for (int g = 0; g < 6; g++) begin
            wait_gnt();
            if (g > 0) check("grant_gap", 32'(cyc - last_g), 32'd2);
            last_g = cyc;
            if (g == 5) bus.req = '0;
        end
        wait_idle();

        // Single burst of four.
        run_burst(4'b0001, 16'h0003);

        // Backpressure: leading entry covers the grant edge.
        ready_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_burst(4'b0100, 16'h0200);

        // Request dropped right after the first beat: all six still delivered.
        run_burst(4'b0010, 16'h0050);

        // Maximum length.
        run_burst(4'b0001, 16'h000F);

        // Reset in the middle of a burst.
        bus.req = 4'b1000;
        bus.len = 16'h7000;
        expect_burst(model_pick(4'b1000), 16'h7000);
        wait_gnt();
        bus.req = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_gnt",   32'(bus.gnt),       32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data",  32'(bus.out_data),  32'd0);
        check("mid_rst_id",    32'(bus.out_id),    32'd0);
        check("mid_rst_last",  32'(bus.out_last),  32'd0);
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        beat_q.delete();
        gnt_q.delete();
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        run_burst(4'hF, 16'($urandom));

        // Randomized traffic with random backpressure.
        ready_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            run_burst(4'($urandom_range(1, 15)), 16'($urandom));
        end
        ready_rand = 1'b0;
        repeat (4) @(posedge clk);

        check("beats_left",  32'(beat_q.size()), 32'd0);
        check("grants_left", 32'(gnt_q.size()),  32'd0);
        w = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + w);
        $finish;
    end

endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
- Shares one free-running `random_uniform` generator among N requesters.
- Each requester asks for a burst of samples. A round-robin arbiter grants one requester at a time and streams its burst over a single shared valid/ready output bus, tagged with the requester id.
- Every beat delivered is a distinct generator sample. Samples are held stable under backpressure.
- Sits between the `random_uniform` output and stochastic consumers (noise injectors, dither, Monte-Carlo stimulus).

Parameters:
- N, 4, number of requesters (2..16).
- OUT_WIDTH, 16, width of generator sample and out_data.
- LEN_W, 4, width of per-requester burst-length field; burst = len+1 samples (1..2^LEN_W).
- ID_W, $clog2(N), width of out_id.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester burst request (level); sampled only in IDLE.
- len  in  N*LEN_W  packed burst lengths; slice i = requester i; value L means L+1 samples.
- gnt  out  N  one-hot, one-cycle pulse marking the accepted requester.
- rng_in  in  OUT_WIDTH  generator sample; new value every clk.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  OUT_WIDTH  random sample.
- out_id  out  ID_W  index of requester owning the current burst.
- out_last  out  1  final beat of burst.
- busy  out  1  high while in STREAM.

Behaviour:
- Reset (rst=0, async), all outputs and state:
  - gnt=0, out_valid=0, out_data=0, out_id=0, out_last=0, busy=0.
  - FSM=IDLE, remaining count=0.
  - RR pointer set so requester 0 has highest priority.
- FSM states: IDLE, STREAM.
- IDLE:
  - On a clk edge with req!=0, pick the first set req bit scanning upward (with wrap) from the RR pointer.
  - At that same edge, register:
    - gnt=onehot(winner), pulsed for exactly one cycle;
    - out_id=winner;
    - remaining=len[winner];
    - out_data=rng_in;
    - out_valid=1, busy=1, out_last=(len[winner]==0);
    - FSM to STREAM.
  - gnt and the first out_valid are therefore asserted in the same cycle, one cycle after req is first sampled high.
- STREAM, handshake (out_valid & out_ready):
  - If out_last: out_valid=0, out_last=0, busy=0, FSM to IDLE, RR pointer = winner+1 mod N.
  - Else: remaining-=1, out_data=rng_in (fresh sample), out_last=(remaining-1==0).
- STREAM, no handshake: out_data, out_id and out_last hold. out_valid stays high; it never drops mid-burst.
- One idle bubble cycle separates consecutive bursts. Arbitration happens only in IDLE.
- Committed bursts:
  - req deassertion during STREAM has no effect; the burst completes.
  - len changes during STREAM are ignored; len is latched at grant.
- Requester i re-requesting immediately after its burst gets lowest priority if others are pending.
- The sample count per burst is exact: len+1 handshakes, out_last on the final one only.
- Reset mid-burst: outputs clear immediately (async). The burst is discarded and no completion is signalled. After release, arbitration restarts from requester 0.
- out_data never repeats a sample across beats: a sample is loaded from rng_in only on a grant or a non-last handshake.

Test Plan (N=4, OUT_WIDTH=16, LEN_W=4):
1. Single burst: req=0001, len0=3, out_ready=1.
   - gnt=0001 for 1 cycle.
   - 4 beats with out_id=0; out_last on beat 4 only.
   - out_data equals rng_in sampled at each load edge.
   - busy falls after beat 4.
2. Fairness: req=1111 held, all len=0, out_ready=1.
   - Grants cycle 0,1,2,3,0,1.
   - Each burst is 1 beat with out_last=1, followed by 1 bubble cycle.
3. Backpressure: req=0100, len2=2, out_ready pattern 0,1,0,0,1,1.
   - out_data and out_last stable while out_ready=0.
   - Exactly 3 handshakes, distinct values, then IDLE.
4. Request drop: req=0010, len1=5; deassert req after beat 1.
   - All 6 beats still delivered with out_id=1; no further grant.
5. Reset mid-burst: start req=1000, len3=7; pull rst low during beat 3.
   - Outputs 0 in the same cycle.
   - After release with req=1111, first gnt=0001.
6. Max length: req=0001, len0=15.
   - 16 beats; out_last only on beat 16; no wrap to an extra beat.
